gf180mcu_fd_io__dvdd_seq: RTL and testbench
===========================================

// Module: gf180mcu_fd_io__dvdd_seq
// PURPOSE
//  Power sequencer for one DVDD/DVSS pad-ring segment: enables the DVDD supply switch, waits for supply-good,
//  settles, then releases pad isolation and input enable. On power-down the order reverses. Sits between the
//  always-on PMU (REQ/ACK handshake) and the pad-ring supply cells; all supply-good inputs are asynchronous.
// PARAMETERS
//  TMO_CYC    1024  max cycles in RAMP waiting for DVDD_OK before fault
//  SETTLE_CYC 64    cycles DVDD_OK must stay high before isolation release (any drop restarts count)
//  OFF_CYC    16    cycles between isolation assert and DVDD_EN deassert on power-down
//  CNT_W      11    counter width; must hold max(TMO_CYC,SETTLE_CYC,OFF_CYC)
// PORTS
//  CLK      in   1  always-on clock
//  RESETN   in   1  asynchronous active-low reset
//  VDD_OK   in   1  core supply good, async, synchronised internally
//  DVDD_OK  in   1  pad supply good comparator, async, synchronised internally
//  REQ      in   1  level request: 1 = segment on, 0 = segment off
//  ACK      out  1  equals REQ once the requested state is reached (four-phase)
//  DVDD_EN  out  1  supply switch enable
//  ISO_N    out  1  pad isolation release (0 = outputs clamped)
//  IE       out  1  pad input enable
//  FAULT    out  1  sticky fault flag; cleared only by REQ=0 reaching OFF
//  STATE    out  3  current state encoding, for observability
// BEHAVIOUR
//  Reset: state OFF; ACK=0, DVDD_EN=0, ISO_N=0, IE=0, FAULT=0, counter=0. Reset mid-sequence forces OFF immediately.
//  Sync: VDD_OK, DVDD_OK via 2-flop synchroniser (reset value 0); 2-cycle input latency, counted in all timing.
//  States (pkg enum): OFF=0, RAMP=1, SETTLE=2, ON=3, DRAIN=4, FLT=5.
//  OFF:    outputs low. REQ=1 & vdd_ok -> RAMP, DVDD_EN=1 registered on entry; counter cleared.
//          REQ=1 & !vdd_ok -> hold OFF, ACK=0.
//  RAMP:   counter++ each cycle. dvdd_ok -> SETTLE (counter cleared). counter==TMO_CYC-1 -> FLT.
//          REQ=0 -> DRAIN.
//  SETTLE: counter++ while dvdd_ok; dvdd_ok=0 -> counter=0, stay. counter==SETTLE_CYC-1 -> ON. REQ=0 -> DRAIN.
//  ON:     ISO_N=1, IE=1, ACK=1. REQ=0 -> DRAIN. dvdd_ok=0 or vdd_ok=0 -> FLT (brown-out).
//  DRAIN:  ISO_N=0, IE=0 on entry; DVDD_EN stays 1 for OFF_CYC cycles, then -> OFF (DVDD_EN=0, ACK=0).
//          REQ=1 during DRAIN ignored until OFF reached.
//  FLT:    FAULT=1, ISO_N=0, IE=0, DVDD_EN=0, ACK held. REQ=0 -> OFF, FAULT cleared on OFF entry.
//  All outputs registered; ISO_N never 1 while DVDD_EN=0; IE==ISO_N always.
//  Simultaneous: REQ=0 with timeout/brown-out in same cycle -> DRAIN wins over FLT.
//  Counter saturates; never wraps.
// CONFIGURATION
//  GF180MCU_FD_IO__DVDD_SEQ_RETRY_EN defined: RAMP timeout -> DRAIN-style off for OFF_CYC, then re-enter
//  RAMP, up to 3 retries (2-bit retry counter, cleared in OFF); 4th timeout -> FLT. Undefined: first timeout -> FLT;
//  no retry logic present.
// STRUCTURE
//  Package gf180mcu_fd_io__pwr_pkg: state enum, STATE encodings, default timing constants.
//  Sub-module gf180mcu_fd_io__sync2: 2-flop async-reset synchroniser, instantiated twice.
//  FSM, counter and output registers in this module.
// TESTING
//  1 Reset, VDD_OK=1, REQ=1, DVDD_OK rises 10 cycles later -> DVDD_EN=1 at cycle 1, ISO_N=IE=ACK=1 after +2 sync +64 settle.
//  2 REQ=1, DVDD_OK held 0 -> FAULT=1 at cycle 1024 of RAMP, DVDD_EN=0; REQ=0 -> OFF, FAULT=0.
//  3 In ON, REQ=0 -> ISO_N=0 next cycle, DVDD_EN=0 16 cycles later, ACK=0.
//  4 SETTLE with DVDD_OK glitch low at count 40 -> count restarts, ON reached 64 cycles after recovery.
//  5 In ON, DVDD_OK drops -> FLT within 3 cycles, ISO_N=0, DVDD_EN=0, FAULT=1.
//  6 RESETN low during SETTLE -> all outputs 0 asynchronously; RETRY_EN build: 3 timeouts retried, 4th faults.

Source files
------------

// File: rtl/gf180mcu_fd_io__pwr_pkg.sv
// Shared types and default timing for the DVDD pad-ring power sequencer.
package gf180mcu_fd_io__pwr_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_RAMP   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ON     = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_FLT    = 3'd5
    } pwr_state_e;

    localparam int unsigned TMO_CYC_DEF    = 1024;
    localparam int unsigned SETTLE_CYC_DEF = 64;
    localparam int unsigned OFF_CYC_DEF    = 16;
    localparam int unsigned CNT_W_DEF      = 11;
    localparam logic [1:0]  RETRY_MAX      = 2'd3;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W_DEF-1:0] sat_inc(input logic [CNT_W_DEF-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_io__sync2.sv
// Two-flop synchroniser with asynchronous active-low reset to 0.
module gf180mcu_fd_io__sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gf180mcu_fd_io__dvdd_seq.sv
// DVDD/DVSS segment power sequencer: supply enable, settle, isolation release and ordered shutdown.
// Optional RAMP-timeout retry behaviour is built when GF180MCU_FD_IO__DVDD_SEQ_RETRY_EN is defined.
module gf180mcu_fd_io__dvdd_seq
    import gf180mcu_fd_io__pwr_pkg::*;
#(
    parameter int unsigned TMO_CYC    = TMO_CYC_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int unsigned OFF_CYC    = OFF_CYC_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       VDD_OK,
    input  logic       DVDD_OK,
    input  logic       REQ,
    output logic       ACK,
    output logic       DVDD_EN,
    output logic       ISO_N,
    output logic       IE,
    output logic       FAULT,
    output logic [2:0] STATE
);

    pwr_state_e       state, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             vdd_ok, dvdd_ok;
    logic             tmo_hit, settle_hit, off_hit;
    logic             ack_nxt, en_nxt, iso_nxt, fault_nxt;
`ifdef GF180MCU_FD_IO__DVDD_SEQ_RETRY_EN
    logic [1:0]       retry_cnt, retry_nxt;
    logic             retry_pend, retry_pend_nxt;
`endif

    gf180mcu_fd_io__sync2 u_sync_vdd (
        .clk   (CLK),
        .rst_n (RESETN),
        .d     (VDD_OK),
        .q     (vdd_ok)
    );

    gf180mcu_fd_io__sync2 u_sync_dvdd (
        .clk   (CLK),
        .rst_n (RESETN),
        .d     (DVDD_OK),
        .q     (dvdd_ok)
    );

    assign cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;
    assign tmo_hit    = (cnt == CNT_W'(TMO_CYC - 1));
    assign settle_hit = (cnt == CNT_W'(SETTLE_CYC - 1));
    assign off_hit    = (cnt == CNT_W'(OFF_CYC - 1));

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
`ifdef GF180MCU_FD_IO__DVDD_SEQ_RETRY_EN
        retry_nxt      = retry_cnt;
        retry_pend_nxt = retry_pend;
`endif
        unique case (state)
            ST_OFF: begin
`ifdef GF180MCU_FD_IO__DVDD_SEQ_RETRY_EN
                retry_nxt      = '0;
                retry_pend_nxt = 1'b0;
`endif
                if (REQ && vdd_ok) nxt = ST_RAMP;
            end
            ST_RAMP: begin
                // A falling request always outranks timeout handling.
                if (!REQ) begin
                    nxt = ST_DRAIN;
                end else if (dvdd_ok) begin
                    nxt = ST_SETTLE;
                end else if (tmo_hit) begin
`ifdef GF180MCU_FD_IO__DVDD_SEQ_RETRY_EN
                    if (retry_cnt != RETRY_MAX) begin
                        nxt            = ST_DRAIN;
                        retry_nxt      = retry_cnt + 2'd1;
                        retry_pend_nxt = 1'b1;
                    end else begin
                        nxt = ST_FLT;
                    end
`else
                    nxt = ST_FLT;
`endif
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_SETTLE: begin
                if (!REQ)            nxt = ST_DRAIN;
                else if (!dvdd_ok)   cnt_nxt = '0;
                else if (settle_hit) nxt = ST_ON;
                else                 cnt_nxt = cnt_inc;
            end
            ST_ON: begin
                if (!REQ)                   nxt = ST_DRAIN;
                else if (!dvdd_ok || !vdd_ok) nxt = ST_FLT;
            end
            ST_DRAIN: begin
                if (off_hit) begin
`ifdef GF180MCU_FD_IO__DVDD_SEQ_RETRY_EN
                    nxt            = (retry_pend && REQ) ? ST_RAMP : ST_OFF;
                    retry_pend_nxt = 1'b0;
`else
                    nxt = ST_OFF;
`endif
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_FLT: begin
                if (!REQ) nxt = ST_OFF;
            end
            default: nxt = ST_OFF;
        endcase

        if (nxt != state) cnt_nxt = '0;

        // Outputs are decoded from the next state so they register in step with it.
        iso_nxt = (nxt == ST_ON);
`ifdef GF180MCU_FD_IO__DVDD_SEQ_RETRY_EN
        en_nxt  = (nxt == ST_RAMP) || (nxt == ST_SETTLE) || (nxt == ST_ON) ||
                  ((nxt == ST_DRAIN) && !retry_pend_nxt);
`else
        en_nxt  = (nxt == ST_RAMP) || (nxt == ST_SETTLE) || (nxt == ST_ON) ||
                  (nxt == ST_DRAIN);
`endif
        ack_nxt = ACK;
        if (nxt == ST_ON)  ack_nxt = 1'b1;
        if (nxt == ST_OFF) ack_nxt = 1'b0;
        fault_nxt = FAULT;
        if (nxt == ST_FLT) fault_nxt = 1'b1;
        if (nxt == ST_OFF) fault_nxt = 1'b0;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state   <= ST_OFF;
            cnt     <= '0;
            ACK     <= 1'b0;
            DVDD_EN <= 1'b0;
            ISO_N   <= 1'b0;
            IE      <= 1'b0;
            FAULT   <= 1'b0;
        end else begin
            state   <= nxt;
            cnt     <= cnt_nxt;
            ACK     <= ack_nxt;
            DVDD_EN <= en_nxt;
            ISO_N   <= iso_nxt;
            IE      <= iso_nxt;
            FAULT   <= fault_nxt;
        end
    end

`ifdef GF180MCU_FD_IO__DVDD_SEQ_RETRY_EN
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
        end else begin
            retry_cnt  <= retry_nxt;
            retry_pend <= retry_pend_nxt;
        end
    end
`endif

    assign STATE = state;

endmodule

// File: tb/tb_gf180mcu_fd_io__dvdd_seq.sv
// Scoreboard bench for gf180mcu_fd_io__dvdd_seq; honours GF180MCU_FD_IO__DVDD_SEQ_RETRY_EN.
module tb_gf180mcu_fd_io__dvdd_seq;
    import gf180mcu_fd_io__pwr_pkg::*;

    logic       CLK = 1'b0;
    logic       RESETN, VDD_OK, DVDD_OK, REQ;
    logic       ACK, DVDD_EN, ISO_N, IE, FAULT;
    logic [2:0] STATE;
    logic [7:0] outv;

    typedef struct {
        string       tag;
        int unsigned at;
        logic [7:0]  exp;
    } exp_t;

    exp_t        sbq[$];
    int unsigned cyc    = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    gf180mcu_fd_io__dvdd_seq dut (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .VDD_OK  (VDD_OK),
        .DVDD_OK (DVDD_OK),
        .REQ     (REQ),
        .ACK     (ACK),
        .DVDD_EN (DVDD_EN),
        .ISO_N   (ISO_N),
        .IE      (IE),
        .FAULT   (FAULT),
        .STATE   (STATE)
    );

    always #5 CLK = ~CLK;

    assign outv = {ACK, DVDD_EN, ISO_N, IE, FAULT, STATE};

    function automatic logic [7:0] mk(logic a, logic e, logic i, logic f, pwr_state_e s);
        return {a, e, i, i, f, 3'(s)};
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input string tag, input int unsigned at, input logic [7:0] e);
        exp_t x;
        x.tag = tag;
        x.at  = at;
        x.exp = e;
        sbq.push_back(x);
    endtask

    task automatic step();
        exp_t x;
        @(negedge CLK);
        cyc++;
        while (sbq.size() != 0 && sbq[0].at <= cyc) begin
            x = sbq.pop_front();
            chk_eq(x.tag, 32'(outv), 32'(x.exp));
        end
    endtask

    task automatic step_to(input int unsigned t);
        while (cyc < t) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned b;
        RESETN = 1'b0; VDD_OK = 1'b1; DVDD_OK = 1'b0; REQ = 1'b0;
        step(); step();
        chk_eq("reset_state", 32'(outv), 32'(mk(0, 0, 0, 0, ST_OFF)));
        RESETN = 1'b1;
        step_to(cyc + 4);

        // Power-up, then power-down with a late request that must be ignored.
        b = cyc; REQ = 1'b1;
        push("ramp_entry",  b + 1,  mk(0, 1, 0, 0, ST_RAMP));
        push("settle_last", b + 76, mk(0, 1, 0, 0, ST_SETTLE));
        push("on_reached",  b + 77, mk(1, 1, 1, 0, ST_ON));
        push("drain_entry", b + 78, mk(1, 1, 0, 0, ST_DRAIN));
        push("drain_hold",  b + 93, mk(1, 1, 0, 0, ST_DRAIN));
        push("drain_done",  b + 94, mk(0, 0, 0, 0, ST_OFF));
        step_to(b + 10); DVDD_OK = 1'b1;
        step_to(b + 77); REQ = 1'b0;
        step_to(b + 85); REQ = 1'b1;
        step_to(b + 94);

        // Re-entry with supply already good, glitch in SETTLE, then brown-out in ON.
        b = cyc;
        push("t4_settle",     b + 2,   mk(0, 1, 0, 0, ST_SETTLE));
        push("glitch_settle", b + 108, mk(0, 1, 0, 0, ST_SETTLE));
        push("glitch_on",     b + 109, mk(1, 1, 1, 0, ST_ON));
        push("bo_on",         b + 111, mk(1, 1, 1, 0, ST_ON));
        push("bo_flt",        b + 112, mk(1, 0, 0, 1, ST_FLT));
        push("flt_clear",     b + 113, mk(0, 0, 0, 0, ST_OFF));
        step_to(b + 42);  DVDD_OK = 1'b0;
        step_to(b + 43);  DVDD_OK = 1'b1;
        step_to(b + 109); DVDD_OK = 1'b0;
        step_to(b + 112); REQ = 1'b0;
        step_to(b + 113);

        // RAMP timeout with DVDD_OK held low.
        b = cyc; REQ = 1'b1;
        push("tmo_ramp", b + 1024, mk(0, 1, 0, 0, ST_RAMP));
`ifdef GF180MCU_FD_IO__DVDD_SEQ_RETRY_EN
        push("rty_drain", b + 1025, mk(0, 0, 0, 0, ST_DRAIN));
        push("rty_ramp2", b + 1041, mk(0, 1, 0, 0, ST_RAMP));
        push("rty_last",  b + 4144, mk(0, 1, 0, 0, ST_RAMP));
        push("tmo_flt",   b + 4145, mk(0, 0, 0, 1, ST_FLT));
        step_to(b + 4145); REQ = 1'b0;
        push("tmo_clear", b + 4146, mk(0, 0, 0, 0, ST_OFF));
        step_to(b + 4146);
`else
        push("tmo_flt", b + 1025, mk(0, 0, 0, 1, ST_FLT));
        step_to(b + 1025); REQ = 1'b0;
        push("tmo_clear", b + 1026, mk(0, 0, 0, 0, ST_OFF));
        step_to(b + 1026);
`endif

        // Asynchronous reset during SETTLE, then request without core supply.
        b = cyc; REQ = 1'b1; DVDD_OK = 1'b1;
        push("rst_settle", b + 3, mk(0, 1, 0, 0, ST_SETTLE));
        step_to(b + 3);
        #2 RESETN = 1'b0;
        #1 chk_eq("async_rst", 32'(outv), 32'(mk(0, 0, 0, 0, ST_OFF)));
        VDD_OK = 1'b0;
        step();
        RESETN = 1'b1;
        push("novdd_hold", cyc + 5, mk(0, 0, 0, 0, ST_OFF));
        step_to(cyc + 5);

        chk_eq("sb_unserved", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
